// File: rtl/button_conditioner_pkg.sv
// Package for the button conditioner.
// Provides the state enum (encodings come from button_defs.vh) and a helper
// that sizes counters to $clog2 of their terminal value, never below 1 bit.
package button_conditioner_pkg;

`include "button_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE  = `BTN_ST_IDLE,
        ST_SHORT = `BTN_ST_SHORT,
        ST_LONG  = `BTN_ST_LONG
    } btn_state_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_defs.vh
// Button conditioner shared definitions.
// Encodings of the press-classification state machine. Kept in a plain
// include so mode-select logic added later can decode the same values
// without pulling in the conditioner package.
`ifndef BUTTON_DEFS_VH
`define BUTTON_DEFS_VH

`define BTN_ST_IDLE  2'd0
`define BTN_ST_SHORT 2'd1
`define BTN_ST_LONG  2'd2

`endif

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high reset; both flops load RESET_VAL
//   d   - asynchronous input
//   q   - synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces an active-low button,
// then classifies each press as a click or a long press.
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset
//   button_in     - raw asynchronous active-low button
//   pressed       - debounced level, 1 while held
//   press_pulse   - one-cycle strobe on the first cycle of pressed=1
//   release_pulse - one-cycle strobe on the first cycle of pressed=0
//   long_pulse    - one-cycle strobe when a press lasts LONG_PRESS_CYCLES
//   click_pulse   - one-cycle strobe with release_pulse when no long_pulse
//                   was issued during that press
//
// state | meaning
// IDLE  | released
// SHORT | pressed, hold counter below long threshold
// LONG  | pressed, long_pulse already issued, hold counter frozen
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic click_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic          sync_btn;
    logic          raw_sync;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          pressed_q, pressed_d;
    logic          rise, fall;
    btn_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          click_q, click_d;

    // Reset value 1 = released, so a held button after reset re-debounces.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (button_in),
        .q  (sync_btn)
    );

    assign raw_sync = ~sync_btn;

    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        if (raw_sync == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d  = '0;
            pressed_d = raw_sync;
        end else begin
            db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    assign rise = pressed_d & ~pressed_q;
    assign fall = ~pressed_d & pressed_q;

    // The FSM reacts to the next debounced level so that state and pulses
    // change on the same edge as pressed. A fall is checked before the
    // threshold so release wins a tie with the long-press threshold.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        click_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (rise) begin
                    state_d = ST_SHORT;
                    press_d = 1'b1;
                end
            end
            ST_SHORT: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            click_q   <= click_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign click_pulse   = click_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive clk cycles the synchronized input must differ from the debounced state before that state updates; legal range is 2 or more.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 100000000, giving the number of clk cycles of debounced press before a long press is declared; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port button_in, input, 1 bit: raw, asynchronous, active-low push-button.
REQ-006 The block SHALL have port pressed, output, 1 bit: debounced level, 1 while the button is held.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on each debounced press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on each debounced release.
REQ-009 The block SHALL have port long_pulse, output, 1 bit: one-cycle strobe when a press reaches LONG_PRESS_CYCLES.
REQ-010 The block SHALL have port click_pulse, output, 1 bit: one-cycle strobe on a release that was not preceded by a long_pulse in the same press.

Function
REQ-011 The block SHALL pass button_in through a two-flop synchronizer and invert the result to form active-high raw_sync.
REQ-012 The debounce counter SHALL clear on any cycle where raw_sync equals pressed.
REQ-013 The debounce counter SHALL increment on any cycle where raw_sync differs from pressed.
REQ-014 When the debounce counter equals DEBOUNCE_CYCLES-1 and raw_sync still differs from pressed, the block SHALL load pressed from raw_sync and clear the counter.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no change on any output.
REQ-016 Latency SHALL be exactly DEBOUNCE_CYCLES+2 clk edges from the first edge sampling the new button_in level to pressed changing.
REQ-017 The state machine SHALL have three states: IDLE (released), SHORT (pressed, below long threshold), LONG (pressed, long_pulse already issued).
REQ-018 The state machine SHALL take IDLE->SHORT in the same cycle pressed rises.
REQ-019 The state machine SHALL take SHORT->LONG when the hold counter reaches LONG_PRESS_CYCLES-1.
REQ-020 The state machine SHALL take SHORT->IDLE and LONG->IDLE in the same cycle pressed falls.
REQ-021 The hold counter SHALL clear in IDLE and increment each cycle in SHORT.
REQ-022 The hold counter SHALL freeze in LONG, so it never wraps.
REQ-023 The press, release, long and click pulses SHALL be registered, each high for exactly one cycle, and aligned with the clk edge on which pressed or the state changes.
REQ-024 press_pulse SHALL coincide with the first cycle pressed=1, and release_pulse with the first cycle pressed=0.
REQ-025 click_pulse SHALL fire together with release_pulse only on SHORT->IDLE; LONG->IDLE fires release_pulse alone.
REQ-026 If pressed falls on the same cycle the hold counter would reach threshold, release SHALL win: click_pulse and release_pulse fire, long_pulse does not.
REQ-027 At most one of press_pulse and release_pulse SHALL be high in any cycle.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter, at least 1 bit.

Reset
REQ-029 While rst=1, the block SHALL hold pressed=0 and all pulses=0, state IDLE, both counters 0, and both synchronizer flops at 1 (released).
REQ-030 Reset asserted mid-press SHALL suppress release_pulse and click_pulse.
REQ-031 After reset deasserts with the button held, the block SHALL re-debounce and issue press_pulse after DEBOUNCE_CYCLES+2 edges.

Structure
REQ-032 State encodings (IDLE=0, SHORT=1, LONG=2) SHALL live in a shared include, button_defs.vh, for reuse by future mode-select logic.
REQ-033 The two-flop synchronizer SHALL be a sub-module, sync_2ff, with ports clk, rst, d, q and reset value parameter.
REQ-034 The block SHALL contain no latches and no combinational outputs.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-035 The bench SHALL cover a clean press: button_in 1->0 held 20 cycles -> pressed rises exactly 6 edges later with press_pulse the same cycle; long_pulse 10 cycles after that; click_pulse stays 0.
REQ-036 The bench SHALL cover a short click: hold low 8 cycles then release -> press_pulse, then release_pulse plus click_pulse together; long_pulse never fires.
REQ-037 The bench SHALL cover bounce: toggle button_in every 2 cycles for 30 cycles, then hold high -> all outputs stay 0 throughout.
REQ-038 The bench SHALL cover a boundary: low for exactly 3 synchronized cycles -> no change; low for exactly 4 -> pressed asserts.
REQ-039 The bench SHALL cover a reset mid-press: assert rst in state LONG for 1 cycle with button held -> outputs 0, no release_pulse, press_pulse again 6 edges after rst falls.
REQ-040 The bench SHALL cover the simultaneous case: release timed so pressed falls on the threshold cycle -> release_pulse and click_pulse, no long_pulse.
